// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared state encoding and counter width helpers for the debouncer
package debounce_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      PEND_P  = 2'b01,
      PRESSED = 2'b11,
      PEND_R  = 2'b10
   } state_e;

   function automatic int cnt_width(input int stable_ticks);
      return (stable_ticks < 1) ? 1 : $clog2(stable_ticks + 1);
   endfunction

   function automatic int hold_width(input int long_ticks);
      return (long_ticks < 1) ? 1 : $clog2(long_ticks + 1);
   endfunction

endpackage

// File: rtl/debouncer_multi_if.sv
// rtl/debouncer_multi_if.sv - button/tick inputs and debounced outputs of the debouncer
interface debouncer_multi_if #(
   parameter int N_CH = 4
);
   logic            tick;
   logic [N_CH-1:0] button;
   logic [N_CH-1:0] level;
   logic [N_CH-1:0] press_pulse;
   logic [N_CH-1:0] release_pulse;
   logic [N_CH-1:0] long_pulse;

   modport master (
      output tick, button,
      input  level, press_pulse, release_pulse, long_pulse
   );

   modport slave (
      input  tick, button,
      output level, press_pulse, release_pulse, long_pulse
   );
endinterface

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one button: synchroniser, stable-time FSM, press/release/long pulses
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int SYNC_STAGES  = 2,
   parameter int STABLE_TICKS = 2,
   parameter int LONG_TICKS   = 250
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic tick_i,
   input  logic button_i,
   output logic level_o,
   output logic press_pulse_o,
   output logic release_pulse_o,
   output logic long_pulse_o
);

   localparam int CNT_W = cnt_width(STABLE_TICKS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_s;
   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   level_q, level_d;
   logic                   press_q, press_d;
   logic                   release_q, release_d;
   logic                   long_q;
   logic                   hold_clr, hold_inc;

   if (SYNC_STAGES > 1) begin : g_sync_chain
      always_ff @(posedge clk_i) begin
         if (rst_i) sync_q <= '0;
         else       sync_q <= {sync_q[SYNC_STAGES-2:0], button_i};
      end
   end else begin : g_sync_single
      always_ff @(posedge clk_i) begin
         if (rst_i) sync_q <= '0;
         else       sync_q <= button_i;
      end
   end

   assign sync_s = sync_q[SYNC_STAGES-1];

   // An input change always wins over a coincident tick: the count restarts.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      hold_clr  = 1'b0;
      hold_inc  = 1'b0;
      case (state_q)
         IDLE: begin
            if (sync_s) begin
               state_d = PEND_P;
               cnt_d   = '0;
            end
         end
         PEND_P: begin
            if (!sync_s) begin
               state_d = IDLE;
            end else if (tick_i) begin
               if (cnt_q == CNT_LAST) begin
                  state_d  = PRESSED;
                  press_d  = 1'b1;
                  hold_clr = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         PRESSED: begin
            if (!sync_s) begin
               state_d = PEND_R;
               cnt_d   = '0;
            end else if (tick_i) begin
               hold_inc = 1'b1;
            end
         end
         PEND_R: begin
            if (sync_s) begin
               state_d = PRESSED;
            end else if (tick_i) begin
               if (cnt_q == CNT_LAST) begin
                  state_d   = IDLE;
                  release_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
      level_d = (state_d == PRESSED) || (state_d == PEND_R);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   if (LONG_TICKS > 0) begin : g_long
      localparam int HOLD_W = hold_width(LONG_TICKS);
      localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_TICKS);
      localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_TICKS - 1);

      logic [HOLD_W-1:0] hold_q, hold_d;
      logic              long_d;

      // Saturation at HOLD_MAX makes the long strobe fire once per press.
      always_comb begin
         hold_d = hold_q;
         long_d = 1'b0;
         if (hold_clr) begin
            hold_d = '0;
         end else if (hold_inc && (hold_q != HOLD_MAX)) begin
            hold_d = hold_q + HOLD_W'(1);
            long_d = (hold_q == HOLD_LAST);
         end
      end

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            hold_q <= '0;
            long_q <= 1'b0;
         end else begin
            hold_q <= hold_d;
            long_q <= long_d;
         end
      end
   end else begin : g_no_long
      logic unused_hold;
      assign unused_hold = hold_clr | hold_inc;
      assign long_q      = 1'b0;
   end

   assign level_o         = level_q;
   assign press_pulse_o   = press_q;
   assign release_pulse_o = release_q;
   assign long_pulse_o    = long_q;

endmodule

// File: rtl/debouncer_multi.sv
// rtl/debouncer_multi.sv - N_CH independent debounce channels sharing one tick strobe
module debouncer_multi #(
   parameter int N_CH         = 4,
   parameter int SYNC_STAGES  = 2,
   parameter int STABLE_TICKS = 2,
   parameter int LONG_TICKS   = 250
) (
   input logic               clk,
   input logic               rst,
   debouncer_multi_if.slave  bus
);

   logic [N_CH-1:0] level_w;
   logic [N_CH-1:0] press_w;
   logic [N_CH-1:0] release_w;
   logic [N_CH-1:0] long_w;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      debounce_channel #(
         .SYNC_STAGES  (SYNC_STAGES),
         .STABLE_TICKS (STABLE_TICKS),
         .LONG_TICKS   (LONG_TICKS)
      ) u_channel (
         .clk_i           (clk),
         .rst_i           (rst),
         .tick_i          (bus.tick),
         .button_i        (bus.button[i]),
         .level_o         (level_w[i]),
         .press_pulse_o   (press_w[i]),
         .release_pulse_o (release_w[i]),
         .long_pulse_o    (long_w[i])
      );
   end

   assign bus.level         = level_w;
   assign bus.press_pulse   = press_w;
   assign bus.release_pulse = release_w;
   assign bus.long_pulse    = long_w;

endmodule

// File: tb/tb_debouncer_multi.sv
// tb/tb_debouncer_multi.sv - vector table plus pulse scoreboard for debouncer_multi
module tb_debouncer_multi;

   logic       clk = 1'b0;
   logic       rst;
   logic       tick;
   logic [3:0] button;
   logic [3:0] button_b;

   always #5 clk = ~clk;

   debouncer_multi_if #(.N_CH(4)) bus_a ();
   debouncer_multi_if #(.N_CH(4)) bus_b ();

   assign bus_a.tick   = tick;
   assign bus_a.button = button;
   assign bus_b.tick   = tick;
   assign bus_b.button = button_b;

   debouncer_multi #(
      .N_CH(4), .SYNC_STAGES(2), .STABLE_TICKS(2), .LONG_TICKS(250)
   ) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   debouncer_multi #(
      .N_CH(4), .SYNC_STAGES(2), .STABLE_TICKS(1), .LONG_TICKS(0)
   ) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   typedef struct {
      logic [3:0] btn;
      logic       tk;
      int         rep;
      logic [3:0] lvl;
      logic [3:0] prs;
      logic [3:0] rel;
   } vec_t;

   typedef struct packed {
      logic [3:0] prs;
      logic [3:0] rel;
      logic [3:0] lng;
   } evt_t;

   vec_t vecs[$];
   vec_t v;
   evt_t sb[$];
   evt_t mon_obs, mon_exp;
   int   n_vec = 0;
   int   n_bad = 0;
   int   b_long_cnt = 0;
   int   b_press_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] outs_a();
      return {bus_a.level, bus_a.press_pulse, bus_a.release_pulse, bus_a.long_pulse};
   endfunction

   function automatic logic [15:0] outs_b();
      return {bus_b.level, bus_b.press_pulse, bus_b.release_pulse, bus_b.long_pulse};
   endfunction

   task automatic add_vec(input logic [3:0] b, input logic t, input int r,
                          input logic [3:0] l, input logic [3:0] p, input logic [3:0] rl);
      vecs.push_back('{b, t, r, l, p, rl});
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_tick();
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
   endtask

   task automatic expect_evt(input logic [3:0] p, input logic [3:0] r, input logic [3:0] l);
      sb.push_back('{p, r, l});
   endtask

   // Every pulse seen on dut_a must match the oldest expected event.
   always @(negedge clk) begin
      mon_obs = '{bus_a.press_pulse, bus_a.release_pulse, bus_a.long_pulse};
      if (mon_obs != '0) begin
         if (sb.size() == 0) begin
            check("sb_unexpected_pulse", 32'(mon_obs), 32'h0);
         end else begin
            mon_exp = sb.pop_front();
            check("sb_event", 32'(mon_obs), 32'(mon_exp));
         end
      end
      if (bus_b.long_pulse != 4'b0)  b_long_cnt++;
      if (bus_b.press_pulse != 4'b0) b_press_cnt++;
   end

   initial begin
      rst      = 1'b1;
      tick     = 1'b0;
      button   = 4'b0;
      button_b = 4'b0;
      cyc(3);
      check("reset_outputs_a", 32'(outs_a()), 32'h0);
      check("reset_outputs_b", 32'(outs_b()), 32'h0);
      rst = 1'b0;

      // btn, tick, repeat, level, press, release
      add_vec(4'b0001, 1'b0,   1, 4'b0000, 4'b0000, 4'b0000);
      add_vec(4'b0001, 1'b0,   1, 4'b0000, 4'b0000, 4'b0000);
      add_vec(4'b0001, 1'b0,   1, 4'b0000, 4'b0000, 4'b0000);
      add_vec(4'b0001, 1'b1,   1, 4'b0000, 4'b0000, 4'b0000);
      add_vec(4'b0001, 1'b0, 100, 4'b0000, 4'b0000, 4'b0000);
      add_vec(4'b0001, 1'b1,   1, 4'b0001, 4'b0001, 4'b0000);
      add_vec(4'b0001, 1'b0,   1, 4'b0001, 4'b0000, 4'b0000);
      add_vec(4'b0011, 1'b0,   1, 4'b0001, 4'b0000, 4'b0000);
      add_vec(4'b0011, 1'b0,   1, 4'b0001, 4'b0000, 4'b0000);
      add_vec(4'b0011, 1'b0,   1, 4'b0001, 4'b0000, 4'b0000);
      add_vec(4'b0011, 1'b1,   1, 4'b0001, 4'b0000, 4'b0000);
      add_vec(4'b0001, 1'b0,   1, 4'b0001, 4'b0000, 4'b0000);
      add_vec(4'b0001, 1'b0,   1, 4'b0001, 4'b0000, 4'b0000);
      add_vec(4'b0001, 1'b1,   1, 4'b0001, 4'b0000, 4'b0000);
      add_vec(4'b0001, 1'b1,   1, 4'b0001, 4'b0000, 4'b0000);
      add_vec(4'b0001, 1'b0,   3, 4'b0001, 4'b0000, 4'b0000);
      add_vec(4'b0000, 1'b0,   1, 4'b0001, 4'b0000, 4'b0000);
      add_vec(4'b0000, 1'b0,   1, 4'b0001, 4'b0000, 4'b0000);
      add_vec(4'b0000, 1'b0,   1, 4'b0001, 4'b0000, 4'b0000);
      add_vec(4'b0000, 1'b1,   1, 4'b0001, 4'b0000, 4'b0000);
      add_vec(4'b0001, 1'b0,   1, 4'b0001, 4'b0000, 4'b0000);
      add_vec(4'b0001, 1'b0,   1, 4'b0001, 4'b0000, 4'b0000);
      add_vec(4'b0001, 1'b1,   1, 4'b0001, 4'b0000, 4'b0000);
      add_vec(4'b0000, 1'b0,   1, 4'b0001, 4'b0000, 4'b0000);
      add_vec(4'b0000, 1'b0,   1, 4'b0001, 4'b0000, 4'b0000);
      add_vec(4'b0000, 1'b0,   1, 4'b0001, 4'b0000, 4'b0000);
      add_vec(4'b0000, 1'b1,   1, 4'b0001, 4'b0000, 4'b0000);
      add_vec(4'b0000, 1'b0,   1, 4'b0001, 4'b0000, 4'b0000);
      add_vec(4'b0000, 1'b1,   1, 4'b0000, 4'b0000, 4'b0001);
      add_vec(4'b0000, 1'b0,   2, 4'b0000, 4'b0000, 4'b0000);

      for (int i = 0; i < vecs.size(); i++) begin
         v      = vecs[i];
         button = v.btn;
         tick   = v.tk;
         if ((v.prs | v.rel) != 4'b0) expect_evt(v.prs, v.rel, 4'b0);
         cyc(v.rep);
         check($sformatf("vec%0d", i), 32'(outs_a()), 32'({v.lvl, v.prs, v.rel, 4'b0000}));
      end
      tick = 1'b0;

      // Long press on ch3: exactly one long strobe at the 250th held tick.
      button = 4'b1000;
      cyc(4);
      expect_evt(4'b1000, 4'b0, 4'b0);
      do_tick();
      do_tick();
      check("ch3_level_pressed", 32'(bus_a.level), 32'h8);
      for (int i = 0; i < 249; i++) begin
         do_tick();
         cyc(1);
      end
      check("ch3_no_long_at_249", 32'(bus_a.long_pulse), 32'h0);
      expect_evt(4'b0, 4'b0, 4'b1000);
      do_tick();
      check("ch3_long_at_250", 32'(bus_a.long_pulse), 32'h8);
      cyc(1);
      check("ch3_long_one_cycle", 32'(bus_a.long_pulse), 32'h0);
      tick = 1'b1;
      cyc(300);
      tick = 1'b0;
      check("ch3_still_pressed", 32'(bus_a.level), 32'h8);
      button = 4'b0000;
      cyc(3);
      expect_evt(4'b0, 4'b1000, 4'b0);
      do_tick();
      do_tick();
      check("ch3_released", 32'(outs_a()), 32'h0080);

      // All channels at once, then reset while ch2 is pending with a qualifying tick.
      button = 4'b1111;
      cyc(4);
      expect_evt(4'b1111, 4'b0, 4'b0);
      do_tick();
      do_tick();
      check("all_level", 32'(bus_a.level), 32'hf);
      button = 4'b0000;
      cyc(3);
      expect_evt(4'b0, 4'b1111, 4'b0);
      do_tick();
      do_tick();
      check("all_released", 32'(bus_a.level), 32'h0);
      button = 4'b0100;
      cyc(4);
      do_tick();
      rst  = 1'b1;
      tick = 1'b1;
      cyc(1);
      check("rst_in_pend_p_a", 32'(outs_a()), 32'h0);
      check("rst_in_pend_p_b", 32'(outs_b()), 32'h0);
      rst    = 1'b0;
      tick   = 1'b0;
      button = 4'b0000;
      do_tick();
      do_tick();
      cyc(4);
      check("after_rst_idle", 32'(outs_a()), 32'h0);

      // Second instance: one-tick stable time, long press disabled.
      button_b = 4'b0001;
      cyc(4);
      do_tick();
      check("b_press_first_tick", 32'(outs_b()), 32'h1100);
      cyc(1);
      check("b_press_one_cycle", 32'(outs_b()), 32'h1000);
      tick = 1'b1;
      cyc(300);
      tick = 1'b0;
      cyc(2);
      check("b_no_long", 32'(b_long_cnt), 32'd0);
      check("b_press_count", 32'(b_press_cnt), 32'd1);
      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
